// File: rtl/dcm_pll_rst_ctrl_pkg.sv
// dcm_pll_rst_ctrl_pkg: state encoding, default timing constants and counter sizing for the DCM/PLL reset sequencer
package dcm_pll_rst_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;
  localparam int DEF_RST_HOLD_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT    = 4096;
  localparam int DEF_STABLE_CYCLES   = 256;
  localparam int DEF_MAX_RETRIES     = 3;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with synchronous active-low clear
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dcm_pll_rst_ctrl.sv
// dcm_pll_rst_ctrl: DCM/PLL reset/lock sequencer with timeout, retry and stable-lock release of system reset
module dcm_pll_rst_ctrl
  import dcm_pll_rst_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_in,
  input  logic       force_rst,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] relock_cnt
);
  localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] retry_nx, retry_inc;
  logic [7:0] relock_nx;
  logic lock_s, give_up;
  sync_2ff u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (locked_in),
    .q    (lock_s)
  );
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    retry_nx  = retry_cnt;
    relock_nx = relock_cnt;
    give_up   = int'(retry_cnt) >= MAX_RETRIES;
    retry_inc = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
    if (force_rst) begin
      state_nx = ST_HOLD;
      cnt_nx   = '0;
      retry_nx = (state == ST_FAIL) ? 2'd0 : retry_cnt;
    end else begin
      case (state)
        ST_HOLD: begin
          state_nx = (cnt == HOLD_LAST) ? ST_WAIT_LOCK : ST_HOLD;
          cnt_nx   = (cnt == HOLD_LAST) ? '0 : cnt + CW'(1);
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nx = give_up ? ST_FAIL : ST_HOLD;
            retry_nx = give_up ? retry_cnt : retry_inc;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_nx = give_up ? ST_FAIL : ST_HOLD;
            retry_nx = give_up ? retry_cnt : retry_inc;
            cnt_nx   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nx = ST_RUN;
            retry_nx = 2'd0;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nx  = ST_HOLD;
            cnt_nx    = '0;
            relock_nx = (relock_cnt == 8'hff) ? relock_cnt : relock_cnt + 8'd1;
          end
        end
        ST_FAIL: begin
          state_nx = ST_FAIL;
        end
        default: begin
          state_nx = ST_HOLD;
          cnt_nx   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      retry_cnt  <= 2'd0;
      relock_cnt <= 8'd0;
      pll_rst    <= 1'b1;
      sys_rst_n  <= 1'b0;
      pll_ready  <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      retry_cnt  <= retry_nx;
      relock_cnt <= relock_nx;
      pll_rst    <= (state_nx == ST_HOLD) || (state_nx == ST_FAIL);
      sys_rst_n  <= state_nx == ST_RUN;
      pll_ready  <= state_nx == ST_RUN;
      fail       <= state_nx == ST_FAIL;
    end
  end
endmodule

// File: tb/tb_dcm_pll_rst_ctrl.sv
// tb_dcm_pll_rst_ctrl: directed scenarios plus randomized lock/force/reset traffic against a cycle-level behavioural model
module tb_dcm_pll_rst_ctrl;
  localparam int RH = 4;
  localparam int TO = 32;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked_in = 1'b0;
  logic force_rst = 1'b0;
  logic pll_rst, sys_rst_n, pll_ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] relock_cnt;
  int checks = 0;
  int errors = 0;
  int m_ph = P_HOLD;
  int m_t = 0;
  int m_retry = 0;
  int m_relock = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  always #5 clk = ~clk;
  dcm_pll_rst_ctrl #(
    .RST_HOLD_CYCLES(RH),
    .LOCK_TIMEOUT   (TO),
    .STABLE_CYCLES  (SC),
    .MAX_RETRIES    (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked_in (locked_in),
    .force_rst (force_rst),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .pll_ready (pll_ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .relock_cnt(relock_cnt)
  );
  task automatic attempt_lost();
    if (m_retry >= MR) m_ph = P_FAIL;
    else begin
      m_retry = (m_retry < 3) ? m_retry + 1 : 3;
      m_ph = P_HOLD;
    end
    m_t = 0;
  endtask
  task automatic tick();
    bit ls;
    @(posedge clk);
    if (!rst_n) begin
      m_ph = P_HOLD; m_t = 0; m_retry = 0; m_relock = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = locked_in;
      if (force_rst) begin
        if (m_ph == P_FAIL) m_retry = 0;
        m_ph = P_HOLD;
        m_t = 0;
      end else if (m_ph == P_HOLD) begin
        m_t++;
        if (m_t == RH) begin m_ph = P_WAIT; m_t = 0; end
      end else if (m_ph == P_WAIT) begin
        if (ls) begin m_ph = P_STABLE; m_t = 0; end
        else begin
          m_t++;
          if (m_t == TO) attempt_lost();
        end
      end else if (m_ph == P_STABLE) begin
        if (!ls) attempt_lost();
        else begin
          m_t++;
          if (m_t == SC) begin m_ph = P_RUN; m_retry = 0; m_t = 0; end
        end
      end else if (m_ph == P_RUN && !ls) begin
        m_ph = P_HOLD;
        m_t = 0;
        if (m_relock < 255) m_relock++;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; force_rst = 0; locked_in = 0;
    tick(); tick();
    checks++;
    if ({pll_rst, sys_rst_n, pll_ready, fail} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: pll_rst/sys_rst_n/pll_ready/fail=%b expected 1000", {pll_rst, sys_rst_n, pll_ready, fail});
    end
    checks++;
    if (retry_cnt !== 2'd0 || relock_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: retry=%0d relock=%0d expected 0 0", retry_cnt, relock_cnt);
    end
  endtask
  task automatic test_normal_lock();
    int n;
    rst_n = 1;
    n = 0;
    do begin tick(); n++; end while (pll_rst && n < 50);
    checks++;
    if (n != RH) begin errors++; $display("FAIL normal_pll_rst_width: %0d cycles expected %0d", n, RH); end
    repeat (10) tick();
    checks++;
    if (sys_rst_n !== 1'b0 || pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL normal_wait: sys_rst_n=%b pll_rst=%b expected 0 0", sys_rst_n, pll_rst);
    end
    locked_in = 1;
    n = 0;
    while (!sys_rst_n && n < 50) begin tick(); n++; end
    checks++;
    if (n != 2 + 1 + SC) begin errors++; $display("FAIL normal_latency: %0d edges expected %0d", n, 2 + 1 + SC); end
    checks++;
    if (pll_ready !== 1'b1 || retry_cnt !== 2'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL normal_run: pll_ready=%b retry=%0d fail=%b expected 1 0 0", pll_ready, retry_cnt, fail);
    end
  endtask
  task automatic test_timeout_retry();
    int n;
    force_rst = 1; locked_in = 0;
    tick();
    force_rst = 0;
    for (int k = 0; k <= MR; k++) begin
      checks++;
      if (retry_cnt !== 2'(k)) begin errors++; $display("FAIL retry_count attempt %0d: retry=%0d expected %0d", k, retry_cnt, k); end
      n = 0;
      while (pll_rst && n < 50) begin tick(); n++; end
      checks++;
      if (n != RH) begin errors++; $display("FAIL retry_pulse attempt %0d: %0d cycles expected %0d", k, n, RH); end
      n = 0;
      while (!pll_rst && n < 100) begin tick(); n++; end
      checks++;
      if (n != TO) begin errors++; $display("FAIL retry_wait attempt %0d: %0d cycles expected %0d", k, n, TO); end
    end
    repeat (20) tick();
    checks++;
    if ({fail, pll_rst, sys_rst_n, pll_ready} !== 4'b1100 || retry_cnt !== 2'(MR)) begin
      errors++;
      $display("FAIL fail_sticky: fail/pll_rst/sys_rst_n/pll_ready=%b retry=%0d expected 1100 %0d", {fail, pll_rst, sys_rst_n, pll_ready}, retry_cnt, MR);
    end
  endtask
  task automatic test_fail_recovery();
    int n;
    force_rst = 1;
    tick();
    force_rst = 0;
    checks++;
    if (fail !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL recover_exit: fail=%b retry=%0d pll_rst=%b expected 0 0 1", fail, retry_cnt, pll_rst);
    end
    locked_in = 1;
    n = 0;
    while (!pll_ready && n < 100) begin tick(); n++; end
    checks++;
    if (n != RH + 1 + SC || sys_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL recover_run: %0d edges sys_rst_n=%b expected %0d 1", n, sys_rst_n, RH + 1 + SC);
    end
  endtask
  task automatic test_lock_loss();
    int n;
    locked_in = 0;
    tick(); tick();
    checks++;
    if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_early: sys_rst_n=%b after 2 edges expected 1", sys_rst_n); end
    tick();
    checks++;
    if (sys_rst_n !== 1'b0 || pll_rst !== 1'b1 || relock_cnt !== 8'd1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL loss_fall: sys_rst_n=%b pll_rst=%b relock=%0d retry=%0d expected 0 1 1 0", sys_rst_n, pll_rst, relock_cnt, retry_cnt);
    end
    n = 0;
    while (pll_rst && n < 50) begin
      if (n == 2) locked_in = 1;
      tick();
      n++;
    end
    checks++;
    if (n != RH) begin errors++; $display("FAIL loss_pulse: %0d cycles expected %0d", n, RH); end
    n = 0;
    while (!pll_ready && n < 100) begin tick(); n++; end
    checks++;
    if (pll_ready !== 1'b1 || relock_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loss_rerun: pll_ready=%b relock=%0d expected 1 1", pll_ready, relock_cnt);
    end
  endtask
  task automatic test_unstable_lock();
    bit saw_run;
    int n;
    force_rst = 1;
    tick();
    force_rst = 0;
    repeat (RH + 1 + 5) tick();
    checks++;
    if (pll_rst !== 1'b0 || sys_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL unstable_entry: pll_rst=%b sys_rst_n=%b expected 0 0", pll_rst, sys_rst_n);
    end
    locked_in = 0;
    saw_run = 0;
    repeat (3) begin tick(); saw_run |= sys_rst_n; end
    checks++;
    if (pll_rst !== 1'b1 || retry_cnt !== 2'd1) begin
      errors++;
      $display("FAIL unstable_retry: pll_rst=%b retry=%0d expected 1 1", pll_rst, retry_cnt);
    end
    repeat (4) begin tick(); saw_run |= sys_rst_n; end
    checks++;
    if (saw_run) begin errors++; $display("FAIL unstable_glitch: sys_rst_n rose=1 expected 0"); end
    locked_in = 1;
    n = 0;
    while (!pll_ready && n < 100) begin tick(); n++; end
    checks++;
    if (pll_ready !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL unstable_rerun: pll_ready=%b retry=%0d expected 1 0", pll_ready, retry_cnt);
    end
  endtask
  task automatic test_corners();
    int n;
    int stuck;
    rst_n = 0; locked_in = 0;
    tick();
    checks++;
    if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || relock_cnt !== 8'd0) begin
      errors++;
      $display("FAIL run_reset: pll_rst=%b sys_rst_n=%b relock=%0d expected 1 0 0", pll_rst, sys_rst_n, relock_cnt);
    end
    rst_n = 1;
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    repeat (TO - 3) tick();
    locked_in = 1;
    repeat (3) tick();
    checks++;
    if (pll_rst !== 1'b0 || retry_cnt !== 2'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL lock_vs_timeout: pll_rst=%b retry=%0d fail=%b expected 0 0 0", pll_rst, retry_cnt, fail);
    end
    n = 0;
    while (!sys_rst_n && n < 50) begin tick(); n++; end
    checks++;
    if (n != SC) begin errors++; $display("FAIL lock_vs_timeout_stable: %0d edges expected %0d", n, SC); end
    stuck = 0;
    for (int i = 0; i < 256; i++) begin
      locked_in = 0;
      n = 0;
      while (sys_rst_n && n < 20) begin tick(); n++; end
      if (n >= 20) stuck++;
      locked_in = 1;
      n = 0;
      while (!pll_ready && n < 100) begin tick(); n++; end
      if (n >= 100) stuck++;
      if (i == 254) begin
        checks++;
        if (relock_cnt !== 8'd255) begin errors++; $display("FAIL relock_255: relock=%0d expected 255", relock_cnt); end
      end
    end
    checks++;
    if (relock_cnt !== 8'd255 || stuck != 0) begin
      errors++;
      $display("FAIL relock_saturate: relock=%0d stalled=%0d expected 255 0", relock_cnt, stuck);
    end
  endtask
  task automatic test_random();
    int rate;
    logic [13:0] got, exp;
    rate = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rate = 4 << (2 * $urandom_range(0, 2));
      rst_n = ($urandom_range(0, 299) != 0);
      force_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, rate - 1) == 0) locked_in = ~locked_in;
      tick();
      got = {pll_rst, sys_rst_n, pll_ready, fail, retry_cnt, relock_cnt};
      exp = {m_ph == P_HOLD || m_ph == P_FAIL, m_ph == P_RUN, m_ph == P_RUN, m_ph == P_FAIL, 2'(m_retry), 8'(m_relock)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: pll_rst/sys_rst_n/pll_ready/fail/retry/relock=%b expected %b", c, got, exp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_normal_lock();
    test_timeout_retry();
    test_fail_recovery();
    test_lock_loss();
    test_unstable_lock();
    test_corners();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
